// File: rtl/int_pe_pkg.sv
// int_pe_pkg: shared constants and range helpers for the integer MAC processing element
package int_pe_pkg;
  localparam int SAT_WRAP  = 0;
  localparam int SAT_CLAMP = 1;
  localparam int MAX_W     = 128;
  function automatic logic signed [MAX_W-1:0] acc_max(input int w);
    logic signed [MAX_W-1:0] one;
    one = 1;
    return (one <<< (w - 1)) - one;
  endfunction
  function automatic logic signed [MAX_W-1:0] acc_min(input int w);
    logic signed [MAX_W-1:0] one;
    one = 1;
    return -(one <<< (w - 1));
  endfunction
  function automatic logic acc_w_ok(input int in_w, input int acc_w);
    return acc_w >= 2 * in_w;
  endfunction
endpackage

// File: rtl/int_sat_add.sv
// int_sat_add: combinational signed adder with overflow flag and optional clamp
//   a_i, b_i : signed addends
//   sum_o    : wrapped sum, or the clamped bound on overflow when SATURATE=SAT_CLAMP
//   ovf_o    : signed overflow of a_i + b_i
module int_sat_add
  import int_pe_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SATURATE = SAT_CLAMP
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(acc_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(acc_min(ACC_W));
  logic signed [ACC_W-1:0] s;
  assign s     = a_i + b_i;
  assign ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (s[ACC_W-1] != a_i[ACC_W-1]);
  // equal-sign overflow means the sign of a_i tells the direction
  assign sum_o = (ovf_o && SATURATE == SAT_CLAMP) ? (a_i[ACC_W-1] ? MINV : MAXV) : s;
endmodule

// File: rtl/int_mac_pe.sv
// int_mac_pe: two-stage signed multiply-accumulate PE with framing, stall and systolic forwarding
//   in_*     : operand beat (valid, first/last framing, activation a, weight b)
//   stall    : freezes every register
//   fwd_*    : inputs registered for the east/south neighbour
//   res_*    : result pulse, accumulated value and sticky overflow of the frame
module int_mac_pe
  import int_pe_pkg::*;
#(
  parameter int IN_W     = 8,
  parameter int ACC_W    = 32,
  parameter int SATURATE = SAT_CLAMP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   in_valid,
  input  logic                   in_first,
  input  logic                   in_last,
  input  logic signed [IN_W-1:0] in_a,
  input  logic signed [IN_W-1:0] in_b,
  output logic                   fwd_valid,
  output logic                   fwd_first,
  output logic                   fwd_last,
  output logic signed [IN_W-1:0] fwd_a,
  output logic signed [IN_W-1:0] fwd_b,
  output logic                   res_valid,
  output logic signed [ACC_W-1:0] res_acc,
  output logic                   res_ovf
);
  localparam int PW = 2 * IN_W;
  if (!acc_w_ok(IN_W, ACC_W)) begin : g_bad_width
    $error("int_mac_pe: ACC_W must be >= 2*IN_W");
  end
  logic signed [PW-1:0]    prod_d, prod_q;
  logic                    v1_q, f1_q, l1_q;
  logic signed [ACC_W-1:0] acc_q, acc_d, p, sum;
  logic                    ovf_q, ovf_d, add_ovf;
  assign prod_d = PW'(in_a) * PW'(in_b);
  assign p      = ACC_W'(prod_q);
  int_sat_add #(.ACC_W(ACC_W), .SATURATE(SATURATE)) u_add (
    .a_i  (acc_q),
    .b_i  (p),
    .sum_o(sum),
    .ovf_o(add_ovf)
  );
  always_comb begin
    acc_d = f1_q ? p : sum;
    ovf_d = f1_q ? 1'b0 : (ovf_q | add_ovf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1_q, f1_q, l1_q, prod_q} <= '0;
      {acc_q, ovf_q}             <= '0;
      {res_valid, res_acc, res_ovf} <= '0;
      {fwd_valid, fwd_first, fwd_last, fwd_a, fwd_b} <= '0;
    end else if (!stall) begin
      {fwd_valid, fwd_first, fwd_last, fwd_a, fwd_b} <= {in_valid, in_first, in_last, in_a, in_b};
      v1_q <= in_valid;
      if (in_valid) {f1_q, l1_q, prod_q} <= {in_first, in_last, prod_d};
      res_valid <= v1_q & l1_q;
      if (v1_q) {acc_q, ovf_q} <= {acc_d, ovf_d};
      if (v1_q && l1_q) {res_acc, res_ovf} <= {acc_d, ovf_d};
    end
  end
endmodule

// File: tb/tb_int_mac_pe.sv
// tb_int_mac_pe: randomized and directed checks of three int_mac_pe configurations against a frame-level model
module tb_int_mac_pe;
  logic clk = 0, rst_n = 0, stall = 0, in_valid = 0, in_first = 0, in_last = 0;
  logic signed [7:0] in_a = 0, in_b = 0;
  logic fv[3], ff[3], fl[3], rv[3], ro[3];
  logic signed [7:0] fa[3], fb[3];
  logic signed [31:0] ra0;
  logic signed [15:0] ra1, ra2;
  logic signed [63:0] oacc[3];
  logic [18:0] fw[3];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  int_mac_pe #(.IN_W(8), .ACC_W(32), .SATURATE(1)) u0 (.clk(clk), .rst_n(rst_n), .stall(stall),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .fwd_valid(fv[0]), .fwd_first(ff[0]), .fwd_last(fl[0]), .fwd_a(fa[0]), .fwd_b(fb[0]),
    .res_valid(rv[0]), .res_acc(ra0), .res_ovf(ro[0]));
  int_mac_pe #(.IN_W(8), .ACC_W(16), .SATURATE(1)) u1 (.clk(clk), .rst_n(rst_n), .stall(stall),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .fwd_valid(fv[1]), .fwd_first(ff[1]), .fwd_last(fl[1]), .fwd_a(fa[1]), .fwd_b(fb[1]),
    .res_valid(rv[1]), .res_acc(ra1), .res_ovf(ro[1]));
  int_mac_pe #(.IN_W(8), .ACC_W(16), .SATURATE(0)) u2 (.clk(clk), .rst_n(rst_n), .stall(stall),
    .in_valid(in_valid), .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b),
    .fwd_valid(fv[2]), .fwd_first(ff[2]), .fwd_last(fl[2]), .fwd_a(fa[2]), .fwd_b(fb[2]),
    .res_valid(rv[2]), .res_acc(ra2), .res_ovf(ro[2]));
  assign oacc[0] = 64'(ra0);
  assign oacc[1] = 64'(ra1);
  assign oacc[2] = 64'(ra2);
  for (genvar g = 0; g < 3; g++) begin : g_fw
    assign fw[g] = {fv[g], ff[g], fl[g], fa[g], fb[g]};
  end
  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic longint add(input longint acc, input longint p, input int w, input bit sat, output bit o);
    longint mx, mn, s;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    s  = acc + p;
    o  = (s > mx) || (s < mn);
    if (!o) return s;
    if (sat) return (s > mx) ? mx : mn;
    return (s > mx) ? s - (longint'(1) << w) : s + (longint'(1) << w);
  endfunction
  typedef struct packed {
    logic [31:0]       due;
    logic [2:0][63:0]  acc;
    logic [2:0]        ovf;
  } res_t;
  res_t rq[$];
  res_t e;
  int W[3] = '{32, 16, 16};
  bit S[3] = '{1'b1, 1'b1, 1'b0};
  longint macc[3], hacc[3], p;
  bit movf[3], hovf[3], hit, o;
  logic [18:0] rec;
  int ne = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      rq.delete();
      rec = '0;
      for (int d = 0; d < 3; d++) begin
        macc[d] = 0; movf[d] = 0; hacc[d] = 0; hovf[d] = 0;
      end
    end else begin
      hit = (rq.size() > 0) && (rq[0].due == 32'(ne + 1));
      for (int d = 0; d < 3; d++) begin
        if (hit) begin
          hacc[d] = longint'($signed(rq[0].acc[d]));
          hovf[d] = rq[0].ovf[d];
        end
        check($sformatf("res_valid%0d", d), 64'(rv[d]), 64'(hit));
        check($sformatf("res_acc%0d", d), oacc[d], hacc[d]);
        check($sformatf("res_ovf%0d", d), 64'(ro[d]), 64'(hovf[d]));
        check($sformatf("fwd%0d", d), 64'(fw[d]), 64'(rec));
      end
      if (!stall) begin
        if (hit) void'(rq.pop_front());
        rec = {in_valid, in_first, in_last, in_a, in_b};
        if (in_valid) begin
          p = longint'(in_a) * longint'(in_b);
          e.due = 32'(ne + 3);
          for (int d = 0; d < 3; d++) begin
            if (in_first) begin
              macc[d] = p; movf[d] = 0;
            end else begin
              macc[d] = add(macc[d], p, W[d], S[d], o);
              movf[d] = movf[d] | o;
            end
            e.acc[d] = 64'(macc[d]);
            e.ovf[d] = movf[d];
          end
          if (in_last) rq.push_back(e);
        end
        ne++;
      end
    end
  end
  task automatic drive(input logic v, input logic f, input logic l, input logic signed [7:0] a,
                       input logic signed [7:0] b, input logic st);
    @(posedge clk);
    #1;
    {in_valid, in_first, in_last, in_a, in_b, stall} = {v, f, l, a, b, st};
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic check_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      check({tag, "_rv"}, 64'(rv[d]), 0);
      check({tag, "_acc"}, oacc[d], 0);
      check({tag, "_ovf"}, 64'(ro[d]), 0);
      check({tag, "_fwd"}, 64'(fw[d]), 0);
    end
  endtask
  initial begin
    #2;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1;
    idle(2);
    drive(1, 1, 1, -128, -128, 0);
    idle(1);
    check("tp_fwd_a", 64'(fa[0]), -128);
    idle(1);
    check("tp_single_rv", 64'(rv[0]), 1);
    check("tp_single_acc", oacc[0], 16384);
    check("tp_single_ovf", 64'(ro[0]), 0);
    idle(2);
    drive(1, 1, 0, 3, 4, 0);
    drive(1, 0, 0, -5, 6, 0);
    drive(1, 0, 0, 7, -1, 0);
    drive(1, 0, 1, 2, 10, 0);
    drive(1, 1, 1, 1, 1, 0);
    idle(1);
    check("tp_four_acc", oacc[0], -5);
    idle(1);
    check("tp_b2b_acc", oacc[0], 1);
    check("tp_b2b_rv", 64'(rv[0]), 1);
    idle(2);
    drive(1, 1, 0, 127, 127, 0);
    drive(1, 0, 0, 127, 127, 0);
    drive(1, 0, 1, 127, 127, 0);
    idle(3);
    check("tp_sat_acc", oacc[1], 32767);
    check("tp_sat_ovf", 64'(ro[1]), 1);
    check("tp_wrap_acc", oacc[2], -17149);
    check("tp_wrap_ovf", 64'(ro[2]), 1);
    check("tp_wide_acc", oacc[0], 48387);
    drive(1, 1, 1, 1, 1, 0);
    idle(3);
    check("tp_sat_next_acc", oacc[1], 1);
    check("tp_sat_next_ovf", 64'(ro[1]), 0);
    drive(1, 1, 0, -128, 127, 0);
    drive(1, 0, 0, -128, 127, 0);
    drive(1, 0, 1, -128, 127, 0);
    idle(3);
    check("tp_neg_sat_acc", oacc[1], -32768);
    check("tp_neg_sat_ovf", 64'(ro[1]), 1);
    drive(1, 1, 0, 3, 4, 0);
    drive(1, 0, 0, -5, 6, 0);
    repeat (3) drive(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1);
    drive(1, 0, 0, 7, -1, 0);
    drive(1, 0, 1, 2, 10, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 99, 99, 1);
    drive(1, 1, 1, 99, 99, 1);
    idle(2);
    check("tp_stall_acc", oacc[0], -5);
    drive(1, 1, 0, 5, 5, 0);
    drive(1, 0, 1, 6, 6, 0);
    drive(0, 0, 0, 0, 0, 0);
    #3 rst_n = 0;
    #1 check_zero("async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    drive(1, 1, 1, 2, 3, 0);
    idle(3);
    check("tp_after_reset_acc", oacc[0], 6);
    repeat (600)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/int_mac_pe.md
# int_mac_pe

Parametrised signed-integer multiply-accumulate processing element for the systolic array. It generalises the fixed int8×int8→int32 multiply and int32 add with overflow detection to configurable operand and accumulator widths, and selects saturating or wrapping accumulation. It adds a two-stage pipeline, first/last framing, a stall input and systolic forwarding of operands to the neighbouring PEs. One instance sits at each array node: operands enter from west/north and leave east/south, and results go to the column drain.

## Interface
Parameters:
- IN_W, default 8: operand width, signed two's complement.
- ACC_W, default 32: accumulator and result width; must be ≥ 2*IN_W (checked by elaboration assertion).
- SATURATE, default 1: 1 = clamp to ACC_W signed range on overflow; 0 = two's-complement wrap.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freeze every register in the PE.
- in_valid  in  1  operand beat valid.
- in_first  in  1  beat starts a new accumulation; qualified by in_valid.
- in_last  in  1  beat ends the accumulation; qualified by in_valid.
- in_a  in  IN_W  signed activation.
- in_b  in  IN_W  signed weight.
- fwd_valid  out  1  registered in_valid, to the neighbour PE.
- fwd_first / fwd_last  out  1 each  registered framing bits.
- fwd_a / fwd_b  out  IN_W each  registered operands.
- res_valid  out  1  one-cycle pulse; res_acc is final.
- res_acc  out  ACC_W  signed accumulated result.
- res_ovf  out  1  an overflow occurred in the accumulation being reported.

## Operation
- Stage 1 (S1): when a beat is accepted (in_valid=1 and stall=0), register the product in_a*in_b (2*IN_W signed) along with valid, first and last.
- Stage 2 (S2): when S1 holds a valid beat and stall=0:
  - Sign-extend the product to ACC_W; call it p.
  - S1 first=1: acc ← p, ovf ← 0.
  - Otherwise: acc ← acc + p.
- Signed overflow on the add: operands have equal sign and the sum sign differs.
  - SATURATE=1: acc ← +2^(ACC_W-1)-1 for positive overflow, −2^(ACC_W-1) for negative overflow.
  - SATURATE=0: acc ← the wrapped sum.
  - ovf ← 1 in both modes. ovf is sticky until the next first beat.
- After saturation, accumulation continues from the clamped value. A later opposite-sign product therefore moves acc back into range.
- S1 last=1: res_valid pulses with res_acc = the new acc and res_ovf = the new ovf.
- first=1 and last=1 on one beat: a single-beat result equal to p, res_ovf=0. p never overflows because ACC_W ≥ 2*IN_W; (−2^(IN_W-1))² fits.
- A beat with first=0 right after reset accumulates onto acc=0.
- Beats with in_valid=0 leave acc, ovf and S1 contents unchanged. They do load S1 valid=0.
- last outside a frame is legal: it reports the current acc.
- Forwarding registers load in_valid/first/last/a/b on every non-stalled edge, whatever the value of in_valid.

## Timing
- Reset (asynchronous assert, synchronous release by the top level): every output, acc, ovf and all pipeline valids are 0.
- Reset mid-accumulation abandons the frame. No res_valid is produced for it.
- Beat accepted at edge E0:
  - Product is registered at E0.
  - acc updates at E1.
  - res_valid is high in the cycle after E1 when last=1.
  - Result latency is 2 cycles.
- Forward latency is 1 cycle: fwd_* reflect the inputs of the previous non-stalled edge.
- Throughput is one beat per cycle. Back-to-back frames are allowed: a first beat may immediately follow a last beat.
- stall=1: all registers hold, including fwd_*, res_valid and res_acc.
  - A res_valid pulse therefore stretches for the duration of the stall; downstream counts a result once per non-stalled cycle.
  - Inputs presented during stall are ignored.
- res_acc holds its last value between pulses.

## Structure
- Shared package int_pe_pkg holds:
  - functions acc_max(ACC_W) and acc_min(ACC_W);
  - the elaboration check ACC_W ≥ 2*IN_W;
  - SATURATE mode constants SAT_WRAP=0 and SAT_CLAMP=1.
- One sub-module, int_sat_add: parametrised ACC_W signed adder with overflow flag and optional clamp, purely combinational. It replaces the fixed 32-bit adder.
- The multiplier is inline: signed multiply followed by sign-extension.

## Test plan
- Single beat, IN_W=8, ACC_W=32: in_a=−128, in_b=−128, first=last=1 → 2 cycles later res_valid=1, res_acc=16384, res_ovf=0. Next cycle fwd_a=−128.
- Four-beat frame: a=3,−5,7,2 with b=4,6,−1,10 → res_acc=12−30−7+20=−5, a single res_valid pulse. An immediately following first=last beat 1×1 → res_acc=1 on the very next cycle.
- Saturation, ACC_W=16, SATURATE=1: three beats of 127×127 → res_acc=32767, res_ovf=1. A next frame of one beat 1×1 → res_acc=1, res_ovf=0.
- Wrap, ACC_W=16, SATURATE=0: three beats of 127×127 → res_acc=−17149, res_ovf=1. Negative case: three beats of −128×127 with SATURATE=1 → res_acc=−32768.
- Stall: stall=1 for 3 cycles in the middle of the four-beat frame above, with garbage inputs applied → same res_acc=−5. fwd_* and res_* are frozen during the stall, and the res_valid pulse stretches if the stall covers it.
- Reset: assert rst_n=0 asynchronously between clock edges after two beats of a frame → all outputs 0 immediately. After release, a frame 2×3 (first=last) → res_acc=6. No stale result appears.
